// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank: per-index RW/RO registers, byte strobes, self-clearing
// pulse bits, SLVERR on unmapped/illegal access, and per-register access strobes.
module axi4_lite_regbank #(
    parameter int unsigned                  DATA_W     = 32,
    parameter int unsigned                  ADDR_W     = 12,
    parameter int unsigned                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]          REG_RO     = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VAL  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]   PULSE_MASK = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_W-1:0]            s_axi_wdata,
    input  logic [DATA_W/8-1:0]          s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_W-1:0]            s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [DATA_W-1:0]            s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [NUM_REGS*DATA_W-1:0]   reg_o,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_i,
    output logic [NUM_REGS-1:0]          wr_pulse_o,
    output logic [NUM_REGS-1:0]          rd_pulse_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - LSB;
    localparam int unsigned FLAT_W = NUM_REGS * DATA_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [FLAT_W-1:0] rw_mask_f();
        logic [FLAT_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (!REG_RO[i]) m[i*DATA_W +: DATA_W] = '1;
        end
        return m;
    endfunction

    function automatic logic [NUM_REGS-1:0] decode_f(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] hit;
        hit = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) hit[i] = 1'b1;
        end
        return hit;
    endfunction

    // RO slices are held at 0 so reg_o drives 0 there.
    localparam logic [FLAT_W-1:0] RST_REGS = RESET_VAL & rw_mask_f();

    logic                rdy_en_q,   rdy_en_d;
    logic                aw_held_q,  aw_held_d;
    logic [IDX_W-1:0]    awidx_q,    awidx_d;
    logic                w_held_q,   w_held_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [STRB_W-1:0]   wstrb_q,    wstrb_d;
    logic                bvalid_q,   bvalid_d;
    logic [1:0]          bresp_q,    bresp_d;
    logic [FLAT_W-1:0]   regs_q,     regs_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic                rvalid_q,   rvalid_d;
    logic [DATA_W-1:0]   rdata_q,    rdata_d;
    logic [1:0]          rresp_q,    rresp_d;
    logic [NUM_REGS-1:0] rd_pulse_q, rd_pulse_d;

    logic                aw_hs, w_hs, ar_hs, commit;
    logic [NUM_REGS-1:0] wr_hit, rd_hit, wr_ok;
    logic                unused_in;

    assign s_axi_awready = rdy_en_q && !aw_held_q && !bvalid_q;
    assign s_axi_wready  = rdy_en_q && !w_held_q && !bvalid_q;
    assign s_axi_arready = rdy_en_q && !rvalid_q;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = aw_held_q && w_held_q;

    assign wr_hit = decode_f(awidx_q);
    assign wr_ok  = wr_hit & ~REG_RO;
    assign rd_hit = decode_f(s_axi_araddr[ADDR_W-1:LSB]);

    // Low address bits and RW slices of reg_i carry no information here.
    assign unused_in = ^{reg_i, s_axi_awaddr, s_axi_araddr};

    // Write channel capture, commit and response.
    always_comb begin
        rdy_en_d   = 1'b1;
        aw_held_d  = aw_held_q;
        awidx_d    = awidx_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q & ~PULSE_MASK;
        wr_pulse_d = '0;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = s_axi_awaddr[ADDR_W-1:LSB];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end

        if (commit) begin
            aw_held_d  = 1'b0;
            w_held_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = (|wr_ok) ? RESP_OKAY : RESP_SLVERR;
            wr_pulse_d = wr_ok;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (wr_ok[i] && wstrb_q[b])
                        regs_d[i*DATA_W + b*8 +: 8] = wdata_q[b*8 +: 8];
                end
            end
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Read capture and response hold.
    always_comb begin
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_pulse_d = '0;

        if (ar_hs) begin
            rvalid_d   = 1'b1;
            rdata_d    = '0;
            rresp_d    = (|rd_hit) ? RESP_OKAY : RESP_SLVERR;
            rd_pulse_d = rd_hit;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (rd_hit[i])
                    rdata_d = REG_RO[i] ? reg_i[i*DATA_W +: DATA_W] : regs_q[i*DATA_W +: DATA_W];
            end
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_en_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            awidx_q    <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            regs_q     <= RST_REGS;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_pulse_q <= '0;
        end else begin
            rdy_en_q   <= rdy_en_d;
            aw_held_q  <= aw_held_d;
            awidx_q    <= awidx_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign reg_o        = regs_q;
    assign wr_pulse_o   = wr_pulse_q;
    assign rd_pulse_o   = rd_pulse_q;

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Directed bench for axi4_lite_regbank: reset, out-of-order write, illegal accesses,
// pulse bits, stalled RO read and reset in the middle of a write.
module tb_axi4_lite_regbank;

    localparam logic [511:0] TB_RST   = 512'h0000_00A5 << 64;
    localparam logic [511:0] TB_PULSE = 512'h0000_0002 << 128;
    localparam logic [15:0]  TB_RO    = 16'h0008;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  awaddr, araddr;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [511:0] reg_o, reg_i, exp_regs;
    logic [15:0]  wr_pulse, rd_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4_lite_regbank #(
        .DATA_W    (32),
        .ADDR_W    (12),
        .NUM_REGS  (16),
        .REG_RO    (TB_RO),
        .RESET_VAL (TB_RST),
        .PULSE_MASK(TB_PULSE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_awaddr (awaddr),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .reg_o        (reg_o),
        .reg_i        (reg_i),
        .wr_pulse_o   (wr_pulse),
        .rd_pulse_o   (rd_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slice(input logic [511:0] v, input int unsigned i);
        return v[i*32 +: 32];
    endfunction

    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, ":awready"}, 32'(awready), 32'(exp));
        chk({tag, ":wready"},  32'(wready),  32'(exp));
        chk({tag, ":arready"}, 32'(arready), 32'(exp));
    endtask

    // Called at a negedge with readys high; returns one negedge after the B handshake.
    task automatic axi_write(input string tag, input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] exp_resp,
                             input logic [15:0] exp_pulse, input logic [511:0] exp_commit);
        chk({tag, ":awready"}, 32'(awready), 32'd1);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk({tag, ":bvalid_e0"}, 32'(bvalid), 32'd0);
        @(negedge clk);
        chk({tag, ":bvalid"},   32'(bvalid),   32'd1);
        chk({tag, ":bresp"},    32'(bresp),    32'(exp_resp));
        chk({tag, ":wr_pulse"}, 32'(wr_pulse), 32'(exp_pulse));
        chk_regs({tag, ":reg_o"}, reg_o, exp_commit);
        @(negedge clk);
        chk({tag, ":bvalid_clr"},   32'(bvalid),   32'd0);
        chk({tag, ":wr_pulse_clr"}, 32'(wr_pulse), 32'd0);
    endtask

    // Called at a negedge with rready high; returns one negedge after the R handshake.
    task automatic axi_read(input string tag, input logic [11:0] a, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
        chk({tag, ":arready"}, 32'(arready), 32'd1);
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk({tag, ":rvalid"},   32'(rvalid),   32'd1);
        chk({tag, ":rdata"},    rdata,         exp_data);
        chk({tag, ":rresp"},    32'(rresp),    32'(exp_resp));
        chk({tag, ":rd_pulse"}, 32'(rd_pulse), 32'(exp_pulse));
        @(negedge clk);
        chk({tag, ":rvalid_clr"},   32'(rvalid),   32'd0);
        chk({tag, ":rd_pulse_clr"}, 32'(rd_pulse), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1; reg_i = '0;
        exp_regs = TB_RST;

        // Reset held for three edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_ready("rst", 1'b0);
        chk("rst:bvalid",   32'(bvalid),   32'd0);
        chk("rst:rvalid",   32'(rvalid),   32'd0);
        chk("rst:rdata",    rdata,         32'd0);
        chk("rst:wr_pulse", 32'(wr_pulse), 32'd0);
        chk("rst:rd_pulse", 32'(rd_pulse), 32'd0);
        chk_regs("rst:reg_o", reg_o, TB_RST);
        rst = 1'b0;
        @(negedge clk);
        chk_ready("rel", 1'b1);
        axi_read("rd2", 12'h008, 32'h0000_00A5, 2'b00, 16'h0004);

        // W three cycles ahead of AW, then B stalled for four cycles.
        wdata = 32'hDEAD_BEEF; wstrb = 4'b0101; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        chk("ooo:wready_held",  32'(wready),  32'd0);
        chk("ooo:awready_idle", 32'(awready), 32'd1);
        repeat (2) @(negedge clk);
        awaddr = 12'h004; awvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0;
        chk("ooo:bvalid_e0", 32'(bvalid), 32'd0);
        @(negedge clk);
        exp_regs[1*32 +: 32] = 32'h00AD_00EF;
        chk("ooo:bvalid",   32'(bvalid),   32'd1);
        chk("ooo:bresp",    32'(bresp),    32'd0);
        chk("ooo:wr_pulse", 32'(wr_pulse), 32'h0002);
        chk("ooo:reg1",     slice(reg_o, 1), 32'h00AD_00EF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ooo:stall_bvalid",   32'(bvalid),   32'd1);
            chk("ooo:stall_awready",  32'(awready),  32'd0);
            chk("ooo:stall_wready",   32'(wready),   32'd0);
            chk("ooo:stall_wr_pulse", 32'(wr_pulse), 32'd0);
        end
        bready = 1'b1;
        @(negedge clk);
        chk("ooo:bvalid_clr", 32'(bvalid),  32'd0);
        chk("ooo:awready",    32'(awready), 32'd1);
        chk("ooo:wready",     32'(wready),  32'd1);

        // Illegal accesses.
        axi_write("wr_unmapped", 12'h040, 32'hFFFF_FFFF, 4'hF, 2'b10, 16'h0000, exp_regs);
        reg_i[3*32 +: 32] = 32'h0000_0011;
        axi_write("wr_ro3", 12'h00C, 32'h1234_5678, 4'hF, 2'b10, 16'h0000, exp_regs);
        axi_read("rd_unmapped", 12'h040, 32'h0, 2'b10, 16'h0000);

        // Pulse bit in reg 4 is high for one cycle only.
        exp_regs[4*32 +: 32] = 32'h0000_0003;
        axi_write("pulse", 12'h010, 32'h0000_0003, 4'hF, 2'b00, 16'h0010, exp_regs);
        chk("pulse:reg4_after", slice(reg_o, 4), 32'h0000_0001);
        @(negedge clk);
        chk("pulse:reg4_later", slice(reg_o, 4), 32'h0000_0001);
        exp_regs[4*32 +: 32] = 32'h0000_0001;

        // RO read held under rready=0 while reg_i changes.
        reg_i[3*32 +: 32] = 32'h0000_0055;
        rready = 1'b0;
        araddr = 12'h00C; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        reg_i[3*32 +: 32] = 32'h0000_0066;
        chk("ro:rvalid",   32'(rvalid),   32'd1);
        chk("ro:rdata",    rdata,         32'h0000_0055);
        chk("ro:rresp",    32'(rresp),    32'd0);
        chk("ro:rd_pulse", 32'(rd_pulse), 32'h0008);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ro:stall_rdata",    rdata,         32'h0000_0055);
            chk("ro:stall_rvalid",   32'(rvalid),   32'd1);
            chk("ro:stall_rd_pulse", 32'(rd_pulse), 32'd0);
            chk("ro:stall_arready",  32'(arready),  32'd0);
        end
        rready = 1'b1;
        @(negedge clk);
        chk("ro:rvalid_clr", 32'(rvalid),  32'd0);
        chk("ro:arready",    32'(arready), 32'd1);
        chk_regs("ro:reg_o", reg_o, exp_regs);

        // Reset after AW only; a later lone W must not commit.
        awaddr = 12'h014; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("mid:awready_held", 32'(awready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_ready("mid_rst", 1'b0);
        @(negedge clk);
        chk_ready("mid_rel", 1'b1);
        chk_regs("mid:reg_o_rst", reg_o, TB_RST);
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        chk("mid:wready_held", 32'(wready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid:bvalid",   32'(bvalid),   32'd0);
            chk("mid:wr_pulse", 32'(wr_pulse), 32'd0);
            chk("mid:reg5",     slice(reg_o, 5), 32'd0);
        end
        chk_regs("mid:reg_o", reg_o, TB_RST);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
